// File: rtl/snoopy_burst_controller_pkg.sv
// Shared command encodings, controller state enum and command-class helpers
// for the snoopy burst controller.
package snoopy_burst_controller_pkg;

  typedef enum logic [1:0] {
    CMD_NONE               = 2'd0,
    CMD_BUS_READ           = 2'd1,
    CMD_BUS_READ_EXCLUSIVE = 2'd2,
    CMD_BUS_INVALIDATE     = 2'd3
  } snoop_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REQUEST,
    ST_SUPPLY,
    ST_UPDATE
  } ctrl_state_e;

  // Commands that may require this cache to source the block.
  function automatic logic cmd_is_read(input logic [1:0] cmd);
    return (cmd == CMD_BUS_READ) || (cmd == CMD_BUS_READ_EXCLUSIVE);
  endfunction

  // Commands that remove our copy of the line.
  function automatic logic cmd_kills_line(input logic [1:0] cmd);
    return (cmd == CMD_BUS_INVALIDATE) || (cmd == CMD_BUS_READ_EXCLUSIVE);
  endfunction

endpackage

// File: rtl/snoopy_burst_controller_counter.sv
// Word-offset counter for a block burst. Wraps naturally at 2**OFFSET_WIDTH.
// 'last' flags the current word as final; 'last_next' flags the value the
// counter will hold after this edge, so the owner can register its own flag.
module snoopy_burst_counter #(
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    advance,
  output logic [OFFSET_WIDTH-1:0] count,
  output logic                    last,
  output logic                    last_next
);

  logic [OFFSET_WIDTH-1:0] count_d;

  // Next count: clear wins over advance.
  always_comb begin
    count_d = count;
    if (clear)        count_d = '0;
    else if (advance) count_d = count + 1'b1;
  end

  assign last      = &count;
  assign last_next = &count_d;

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) count <= '0;
    else        count <= count_d;
  end

endmodule

// File: rtl/snoopy_burst_controller.sv
// Snoop responder: looks up a snooped block, optionally bursts it onto the
// data bus (resuming cleanly if the grant is pulled), then updates or
// invalidates the local line.
module snoopy_burst_controller
  import snoopy_burst_controller_pkg::*;
#(
  parameter int OFFSET_WIDTH  = 4,
  parameter int INDEX_WIDTH   = 4,
  parameter int TAG_WIDTH     = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int STATE_WIDTH   = 2,
  parameter int INVALID_STATE = 0,
  localparam int ADDRESS_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     snoop_valid,
  input  logic [1:0]               snoop_command,
  input  logic [ADDRESS_WIDTH-1:0] snoop_address,
  output logic                     snoop_ready,
  output logic [ADDRESS_WIDTH-1:0] cache_address,
  input  logic                     cache_hit,
  input  logic [STATE_WIDTH-1:0]   cache_state,
  input  logic [DATA_WIDTH-1:0]    cache_data,
  output logic                     cache_state_write,
  output logic [STATE_WIDTH-1:0]   protocol_state,
  output logic [1:0]               protocol_command,
  input  logic [STATE_WIDTH-1:0]   protocol_next_state,
  input  logic                     protocol_supply,
  output logic                     bus_request,
  input  logic                     bus_grant,
  output logic [DATA_WIDTH-1:0]    supply_data,
  output logic                     supply_valid,
  output logic                     supply_last,
  input  logic                     supply_ready,
  output logic                     invalidate_enable
);

  localparam int BLOCK_WIDTH = TAG_WIDTH + INDEX_WIDTH;

  ctrl_state_e             state_q, state_d;
  logic [1:0]              cmd_q;
  logic [BLOCK_WIDTH-1:0]  block_q;
  logic                    latch, cnt_clear, cnt_advance;
  logic [OFFSET_WIDTH-1:0] cnt;
  logic                    cnt_last, cnt_last_next;
  logic                    ready_q, req_q, valid_q, last_q, csw_q, inv_q;
  logic                    ready_d, req_d, valid_d, last_d, csw_d, inv_d;

  snoopy_burst_counter #(.OFFSET_WIDTH(OFFSET_WIDTH)) u_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (cnt_clear),
    .advance   (cnt_advance),
    .count     (cnt),
    .last      (cnt_last),
    .last_next (cnt_last_next)
  );

  // Next-state logic plus next values of the registered outputs. A dropped
  // grant in SUPPLY suppresses the handshake so the same word is re-offered.
  always_comb begin
    state_d     = state_q;
    latch       = 1'b0;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (snoop_valid && (snoop_command != CMD_NONE)) begin
          latch   = 1'b1;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (cache_hit && protocol_supply && cmd_is_read(cmd_q)) begin
          cnt_clear = 1'b1;
          state_d   = ST_REQUEST;
        end else begin
          state_d = ST_UPDATE;
        end
      end
      ST_REQUEST: begin
        if (bus_grant) state_d = ST_SUPPLY;
      end
      ST_SUPPLY: begin
        if (!bus_grant) begin
          state_d = ST_REQUEST;
        end else if (supply_ready) begin
          cnt_advance = 1'b1;
          if (cnt_last) state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    req_d   = (state_d == ST_REQUEST) || (state_d == ST_SUPPLY);
    valid_d = (state_d == ST_SUPPLY);
    last_d  = (state_d == ST_SUPPLY) && cnt_last_next;
    csw_d   = (state_d == ST_UPDATE) && cache_hit && (protocol_next_state != cache_state);
    inv_d   = (state_d == ST_UPDATE) && cache_hit && cmd_kills_line(cmd_q);
  end

  // State, latched command/block and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NONE;
      block_q <= '0;
      ready_q <= 1'b1;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      csw_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        cmd_q   <= snoop_command;
        block_q <= snoop_address[ADDRESS_WIDTH-1:OFFSET_WIDTH];
      end
      ready_q <= ready_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      csw_q   <= csw_d;
      inv_q   <= inv_d;
    end
  end

  assign snoop_ready       = ready_q;
  assign bus_request       = req_q;
  assign supply_valid      = valid_q;
  assign supply_last       = last_q;
  assign cache_state_write = csw_q;
  assign invalidate_enable = inv_q;
  assign protocol_command  = cmd_q;
  assign cache_address     = {block_q, cnt};
  // Lookup result is only meaningful while a snoop is in flight.
  assign protocol_state    = ((state_q != ST_IDLE) && cache_hit) ? cache_state
                                                                 : STATE_WIDTH'(INVALID_STATE);
  assign supply_data       = valid_q ? cache_data : '0;

endmodule

// File: tb/tb_snoopy_burst_controller.sv
// Scoreboard bench for snoopy_burst_controller: the driver pushes expected
// burst words, a negedge monitor pops and compares on every accepted word.
module tb_snoopy_burst_controller;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          snoop_valid = 1'b0;
  logic [1:0]    snoop_command = 2'd0;
  logic [AW-1:0] snoop_address = '0;
  logic          snoop_ready;
  logic [AW-1:0] cache_address;
  logic          cache_hit = 1'b0;
  logic [1:0]    cache_state = 2'd0;
  logic [DW-1:0] cache_data;
  logic          cache_state_write;
  logic [1:0]    protocol_state;
  logic [1:0]    protocol_command;
  logic [1:0]    protocol_next_state = 2'd0;
  logic          protocol_supply = 1'b0;
  logic          bus_request;
  logic          bus_grant = 1'b0;
  logic [DW-1:0] supply_data;
  logic          supply_valid;
  logic          supply_last;
  logic          supply_ready = 1'b0;
  logic          invalidate_enable;

  snoopy_burst_controller dut (
    .clock               (clock),
    .reset               (reset),
    .snoop_valid         (snoop_valid),
    .snoop_command       (snoop_command),
    .snoop_address       (snoop_address),
    .snoop_ready         (snoop_ready),
    .cache_address       (cache_address),
    .cache_hit           (cache_hit),
    .cache_state         (cache_state),
    .cache_data          (cache_data),
    .cache_state_write   (cache_state_write),
    .protocol_state      (protocol_state),
    .protocol_command    (protocol_command),
    .protocol_next_state (protocol_next_state),
    .protocol_supply     (protocol_supply),
    .bus_request         (bus_request),
    .bus_grant           (bus_grant),
    .supply_data         (supply_data),
    .supply_valid        (supply_valid),
    .supply_last         (supply_last),
    .supply_ready        (supply_ready),
    .invalidate_enable   (invalidate_enable)
  );

  always #5 clock = ~clock;

  // Cache data array model: each word's contents derive from its address.
  assign cache_data = {cache_address ^ 16'h5A5A, 16'hBEEF};

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   errors = 0;
  int   hs_cnt = 0, csw_cnt = 0, inv_cnt = 0, req_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pulse counters and scoreboard pop on each accepted word.
  always @(negedge clock) begin
    if (reset) begin
      if (cache_state_write) csw_cnt++;
      if (invalidate_enable) inv_cnt++;
      if (bus_request)       req_cnt++;
      if (supply_valid && supply_ready && bus_grant) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(supply_data), 64'hFFFF_FFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data", 64'(supply_data), 64'(mon_e.data));
          check("word_addr", 64'(cache_address), 64'(mon_e.addr));
          check("word_last", 64'(supply_last), 64'(mon_e.last));
        end
      end
    end
  end

  // One snoop transaction. drop_at/rst_at (-1 = unused) act when that many
  // words have been accepted; exp_lat is cycles from accept back to ready.
  task automatic snoop(input string nm, input logic [1:0] cmd, input logic [AW-1:0] addr,
                       input logic hit, input logic [1:0] st, input logic [1:0] nst,
                       input logic sup, input int exp_lat, input int drop_at, input int rst_at);
    int   c0, i0, r0, h0, cycles, low;
    logic done, dropped, exp_req;
    exp_t e;
    exp_req = hit && sup && (cmd == 2'd1 || cmd == 2'd2);
    cache_hit = hit; cache_state = st; protocol_next_state = nst; protocol_supply = sup;
    bus_grant = 1'b1; supply_ready = 1'b1;
    c0 = csw_cnt; i0 = inv_cnt; r0 = req_cnt; h0 = hs_cnt;
    if (exp_req)
      for (int i = 0; i < 16; i++) begin
        e.addr = (addr & 16'hFFF0) | 16'(i);
        e.data = {e.addr ^ 16'h5A5A, 16'hBEEF};
        e.last = (i == 15);
        exp_q.push_back(e);
      end
    snoop_valid = 1'b1; snoop_command = cmd; snoop_address = addr;
    @(posedge clock); #1;
    snoop_valid = 1'b0; snoop_command = 2'd0;
    check({nm, "_cmd"}, 64'(protocol_command), 64'(cmd));
    cycles = 0; done = 1'b0; dropped = 1'b0; low = 0;
    while (!done && cycles < 200) begin
      @(posedge clock); #1;
      cycles++;
      if (rst_at >= 0 && (hs_cnt - h0) == rst_at) begin
        reset = 1'b0;
        @(posedge clock); #1;
        check({nm, "_rst_ctrl"},
              64'({snoop_ready, bus_request, supply_valid, supply_last,
                   cache_state_write, invalidate_enable}), 64'b100000);
        check({nm, "_rst_addr"}, 64'(cache_address), 64'h0);
        check({nm, "_rst_data"}, 64'(supply_data), 64'h0);
        check({nm, "_rst_pstate"}, 64'({protocol_state, protocol_command}), 64'h0);
        reset = 1'b1;
        exp_q.delete();
        check({nm, "_rst_nowrite"}, 64'(csw_cnt - c0), 64'd0);
        return;
      end
      if (drop_at >= 0 && !dropped && (hs_cnt - h0) == drop_at) begin
        bus_grant = 1'b0; dropped = 1'b1;
      end else if (dropped && !bus_grant) begin
        low++;
        if (low == 3) bus_grant = 1'b1;
      end
      if (snoop_ready) done = 1'b1;
    end
    check({nm, "_timeout"}, 64'(done), 64'd1);
    check({nm, "_latency"}, 64'(cycles), 64'(exp_lat));
    check({nm, "_csw"}, 64'(csw_cnt - c0), 64'((hit && nst != st) ? 1 : 0));
    check({nm, "_inv"}, 64'(inv_cnt - i0), 64'((hit && (cmd == 2'd3 || cmd == 2'd2)) ? 1 : 0));
    check({nm, "_req"}, 64'((req_cnt - r0) > 0), 64'(exp_req));
    check({nm, "_words"}, 64'(hs_cnt - h0), 64'(exp_req ? 16 : 0));
    check({nm, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_ctrl", 64'({snoop_ready, bus_request, supply_valid, supply_last,
                             cache_state_write, invalidate_enable}), 64'b100000);
    check("reset_addr", 64'(cache_address), 64'h0);
    check("reset_cmd", 64'(protocol_command), 64'h0);
    reset = 1'b1;
    @(posedge clock); #1;

    //    name        cmd   addr      hit  st    nst   sup  lat drop rst
    snoop("miss",     2'd1, 16'h0123, 0,   2'd0, 2'd0, 0,   2,  -1,  -1);
    snoop("burst",    2'd1, 16'h4560, 1,   2'd3, 2'd1, 1,   19, -1,  -1);
    snoop("regrant",  2'd1, 16'h7A30, 1,   2'd3, 2'd1, 1,   23, 6,   -1);
    snoop("inval",    2'd3, 16'h2210, 1,   2'd1, 2'd0, 0,   2,  -1,  -1);
    snoop("rdx",      2'd2, 16'hFFF0, 1,   2'd2, 2'd0, 1,   19, -1,  -1);
    snoop("hit_same", 2'd1, 16'h0B00, 1,   2'd1, 2'd1, 0,   2,  -1,  -1);

    // NONE command must not be accepted.
    snoop_valid = 1'b1; snoop_command = 2'd0; snoop_address = 16'h1110;
    @(posedge clock); #1;
    snoop_valid = 1'b0;
    check("none_ignored", 64'({snoop_ready, bus_request}), 64'b10);

    snoop("rst_burst", 2'd1, 16'h3C40, 1,  2'd3, 2'd1, 1,   0,  -1,  9);
    @(posedge clock); #1;
    snoop("post_rst", 2'd1, 16'h0123, 0,   2'd0, 2'd0, 0,   2,  -1,  -1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/snoopy_burst_controller.md
SNOOPY_BURST_CONTROLLER -- requirements
Module: snoopy_burst_controller

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  OFFSET_WIDTH, 4, word-offset bits; block = 2**OFFSET_WIDTH words
  INDEX_WIDTH, 4, set-index bits
  TAG_WIDTH, 8, tag bits; ADDRESS_WIDTH = TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH
  DATA_WIDTH, 32, word width
  STATE_WIDTH, 2, coherence-state width
  INVALID_STATE, 0, encoding of the invalid state
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clock  in  1  single clock; all logic on rising edge
  reset  in  1  synchronous, active-low reset
  snoop_valid  in  1  snooped bus command present
  snoop_command  in  2  NONE / BUS_READ / BUS_READ_EXCLUSIVE / BUS_INVALIDATE
  snoop_address  in  ADDRESS_WIDTH  snooped block address
  snoop_ready  out  1  idle; command accepted when snoop_valid && snoop_ready
  cache_address  out  ADDRESS_WIDTH  latched tag/index; offset = burst counter
  cache_hit  in  1  tag match, valid line
  cache_state  in  STATE_WIDTH  stored state of the hit line
  cache_data  in  DATA_WIDTH  word at cache_address, combinational
  cache_state_write  out  1  one-cycle pulse; cache writes protocol_next_state
  protocol_state  out  STATE_WIDTH  cache_state on hit, else INVALID_STATE
  protocol_command  out  2  latched command
  protocol_next_state  in  STATE_WIDTH  state after snoop
  protocol_supply  in  1  this cache must supply the block
  bus_request  out  1  request data-bus ownership
  bus_grant  in  1  ownership granted; may drop at any cycle
  supply_data  out  DATA_WIDTH  supplied word
  supply_valid  out  1  supply_data valid
  supply_last  out  1  marks final word of the block
  supply_ready  in  1  bus accepts the word
  invalidate_enable  out  1  one-cycle pulse: line invalidated

Function
REQ-003 The FSM SHALL have states IDLE, LOOKUP, REQUEST, SUPPLY, UPDATE.
REQ-004 IDLE: snoop_ready=1; on snoop_valid with command != NONE, latch command and address, go to LOOKUP; NONE is ignored.
REQ-005 LOOKUP (one cycle): hit && protocol_supply && command in {BUS_READ, BUS_READ_EXCLUSIVE} -> REQUEST with counter=0; otherwise -> UPDATE.
REQ-006 REQUEST: bus_request=1; bus_grant=1 -> SUPPLY.
REQ-007 SUPPLY: bus_request=1, supply_valid=1, supply_data=cache_data at the counter offset; counter increments on supply_valid && supply_ready.
REQ-008 SUPPLY: supply_last=1 when counter == 2**OFFSET_WIDTH-1; accepting that word -> UPDATE.
REQ-009 Grant dropped in SUPPLY SHALL return to REQUEST without a handshake that cycle; the counter is kept and the burst resumes at the same word, with no word lost or repeated.
REQ-010 UPDATE (one cycle): cache_state_write=1 when hit and protocol_next_state != cache_state; invalidate_enable=1 when hit and command in {BUS_INVALIDATE, BUS_READ_EXCLUSIVE}; -> IDLE.
REQ-011 A miss SHALL pass through LOOKUP and UPDATE with no writes, no request and no supply (2-cycle latency).
REQ-012 Outputs are registered except cache_address, protocol_state and supply_data, which are combinational from latched state and the counter; counter arithmetic is OFFSET_WIDTH bits and wraps to 0.

Reset
REQ-013 reset low at a clock edge SHALL, even mid-burst, force IDLE and counter=0 with every output low except snoop_ready=1; no state write occurs.

Structure
REQ-014 The command encodings and the FSM state enum SHALL live in the shared commands package.
REQ-015 The burst counter with its last-word flag is one natural sub-module: snoopy_burst_counter.

Verification
REQ-016 Miss on BUS_READ at 0x123 -> back in IDLE after 2 cycles; no bus_request, no cache_state_write, no invalidate_enable.
REQ-017 Hit, supply=1, grant immediate, supply_ready constant 1 -> 16 consecutive words at offsets 0..15, supply_last on word 15, then one cache_state_write pulse.
REQ-018 Grant dropped after word 5 and regranted 3 cycles later -> burst resumes at word 6; 16 words total, none repeated.
REQ-019 BUS_INVALIDATE on a hit -> invalidate_enable and cache_state_write each high for exactly one cycle; no bus_request.
REQ-020 reset low during word 9 of a burst -> next cycle in IDLE, all outputs low, snoop_ready=1, no state write.
